// File: rtl/rv_mem_bus_arbiter.sv
// Shares one external memory bus between the instruction-fetch and data ports.
// Round-robin grant, slave wait states, bus timeout, and one-cycle ack/err pulses back to the requester.
module rv_mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_ibus_req,
  input  logic [29:0] i_ibus_addr,
  output logic [31:0] o_ibus_rdata,
  output logic        o_ibus_ack,
  output logic        o_ibus_err,
  input  logic        i_dbus_req,
  input  logic        i_dbus_we,
  input  logic [3:0]  i_dbus_sel,
  input  logic [31:0] i_dbus_addr,
  input  logic [31:0] i_dbus_wdata,
  output logic [31:0] o_dbus_rdata,
  output logic        o_dbus_ack,
  output logic        o_dbus_err,
  output logic        o_bus_cyc,
  output logic        o_bus_we,
  output logic [3:0]  o_bus_sel,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ack,
  input  logic        i_bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_IBUS, S_DBUS, S_RESP} state_e;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic        last_dbus_q, last_dbus_d;   // 0 = instruction port was granted last
  logic [15:0] cnt_q, cnt_d, cnt_next;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ibus_rdata_q, ibus_rdata_d;
  logic        ibus_ack_q, ibus_ack_d;
  logic        ibus_err_q, ibus_err_d;
  logic [31:0] dbus_rdata_q, dbus_rdata_d;
  logic        dbus_ack_q, dbus_ack_d;
  logic        dbus_err_q, dbus_err_d;
  logic        bus_ok;

  assign cnt_next = cnt_q + 16'd1;
  // An error response beats an ack; an ack beats a timeout in the same cycle.
  assign bus_ok   = i_bus_ack && !i_bus_err;

  always_comb begin
    state_d      = state_q;
    last_dbus_d  = last_dbus_q;
    cnt_d        = cnt_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ibus_rdata_d = ibus_rdata_q;
    dbus_rdata_d = dbus_rdata_q;
    ibus_ack_d   = 1'b0;
    ibus_err_d   = 1'b0;
    dbus_ack_d   = 1'b0;
    dbus_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_dbus_req && (!i_ibus_req || !last_dbus_q)) begin
          state_d     = S_DBUS;
          last_dbus_d = 1'b1;
          cnt_d       = 16'd0;
          cyc_d       = 1'b1;
          we_d        = i_dbus_we;
          sel_d       = i_dbus_sel;
          addr_d      = i_dbus_addr;
          wdata_d     = i_dbus_wdata;
        end else if (i_ibus_req) begin
          state_d     = S_IBUS;
          last_dbus_d = 1'b0;
          cnt_d       = 16'd0;
          cyc_d       = 1'b1;
          we_d        = 1'b0;
          sel_d       = 4'hF;
          addr_d      = {i_ibus_addr, 2'b00};
          wdata_d     = 32'd0;
        end
      end
      S_IBUS, S_DBUS: begin
        if (i_bus_err || i_bus_ack || (cnt_next == TIMEOUT_LIMIT)) begin
          state_d = S_RESP;
          cyc_d   = 1'b0;
          cnt_d   = 16'd0;
          if (state_q == S_IBUS) begin
            ibus_ack_d = bus_ok;
            ibus_err_d = !bus_ok;
            if (bus_ok) ibus_rdata_d = i_bus_rdata;
          end else begin
            dbus_ack_d = bus_ok;
            dbus_err_d = !bus_ok;
            if (bus_ok) dbus_rdata_d = i_bus_rdata;
          end
        end else begin
          cnt_d = cnt_next;
        end
      end
      // One dead cycle lets a requester drop req before the next arbitration.
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= S_IDLE;
      last_dbus_q  <= 1'b0;
      cnt_q        <= 16'd0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= 4'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      ibus_rdata_q <= 32'd0;
      ibus_ack_q   <= 1'b0;
      ibus_err_q   <= 1'b0;
      dbus_rdata_q <= 32'd0;
      dbus_ack_q   <= 1'b0;
      dbus_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_dbus_q  <= last_dbus_d;
      cnt_q        <= cnt_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ibus_rdata_q <= ibus_rdata_d;
      ibus_ack_q   <= ibus_ack_d;
      ibus_err_q   <= ibus_err_d;
      dbus_rdata_q <= dbus_rdata_d;
      dbus_ack_q   <= dbus_ack_d;
      dbus_err_q   <= dbus_err_d;
    end
  end

  assign o_ibus_rdata = ibus_rdata_q;
  assign o_ibus_ack   = ibus_ack_q;
  assign o_ibus_err   = ibus_err_q;
  assign o_dbus_rdata = dbus_rdata_q;
  assign o_dbus_ack   = dbus_ack_q;
  assign o_dbus_err   = dbus_err_q;
  assign o_bus_cyc    = cyc_q;
  assign o_bus_we     = we_q;
  assign o_bus_sel    = sel_q;
  assign o_bus_addr   = addr_q;
  assign o_bus_wdata  = wdata_q;

endmodule

// File: tb/tb_rv_mem_bus_arbiter.sv
// Directed bench for rv_mem_bus_arbiter with an 8-cycle timeout.
// Each scenario task drives stimulus and checks inline against hand-computed values.
module tb_rv_mem_bus_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_ibus_req;
  logic [29:0] i_ibus_addr;
  logic [31:0] o_ibus_rdata;
  logic        o_ibus_ack, o_ibus_err;
  logic        i_dbus_req, i_dbus_we;
  logic [3:0]  i_dbus_sel;
  logic [31:0] i_dbus_addr, i_dbus_wdata;
  logic [31:0] o_dbus_rdata;
  logic        o_dbus_ack, o_dbus_err;
  logic        o_bus_cyc, o_bus_we;
  logic [3:0]  o_bus_sel;
  logic [31:0] o_bus_addr, o_bus_wdata;
  logic [31:0] i_bus_rdata;
  logic        i_bus_ack, i_bus_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [137:0] all_out;
  logic [69:0]  bus_vec;
  assign all_out = {o_ibus_rdata, o_ibus_ack, o_ibus_err, o_dbus_rdata, o_dbus_ack, o_dbus_err,
                    o_bus_cyc, o_bus_we, o_bus_sel, o_bus_addr, o_bus_wdata};
  assign bus_vec = {o_bus_cyc, o_bus_we, o_bus_sel, o_bus_addr, o_bus_wdata};

  rv_mem_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_ibus_req(i_ibus_req), .i_ibus_addr(i_ibus_addr),
    .o_ibus_rdata(o_ibus_rdata), .o_ibus_ack(o_ibus_ack), .o_ibus_err(o_ibus_err),
    .i_dbus_req(i_dbus_req), .i_dbus_we(i_dbus_we), .i_dbus_sel(i_dbus_sel),
    .i_dbus_addr(i_dbus_addr), .i_dbus_wdata(i_dbus_wdata),
    .o_dbus_rdata(o_dbus_rdata), .o_dbus_ack(o_dbus_ack), .o_dbus_err(o_dbus_err),
    .o_bus_cyc(o_bus_cyc), .o_bus_we(o_bus_we), .o_bus_sel(o_bus_sel),
    .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
    .i_bus_rdata(i_bus_rdata), .i_bus_ack(i_bus_ack), .i_bus_err(i_bus_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_ibus_req = 1'b0; i_ibus_addr = '0;
    i_dbus_req = 1'b0; i_dbus_we = 1'b0; i_dbus_sel = '0; i_dbus_addr = '0; i_dbus_wdata = '0;
    i_bus_ack = 1'b0; i_bus_err = 1'b0;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_ibus_req = 1'($urandom); i_ibus_addr = 30'($urandom);
      i_dbus_req = 1'($urandom); i_dbus_we = 1'($urandom); i_dbus_sel = 4'($urandom);
      i_dbus_addr = $urandom; i_dbus_wdata = $urandom; i_bus_rdata = $urandom;
      i_bus_ack = 1'($urandom); i_bus_err = 1'($urandom);
      tick();
      vec_cnt++;
      if (all_out !== '0) begin
        err_cnt++; $display("FAIL reset_outputs: got %h expected 0", all_out);
      end
    end
    idle_inputs();
    @(negedge i_clk);
    i_reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vec_cnt++;
      if (o_bus_cyc !== 1'b0) begin
        err_cnt++; $display("FAIL reset_idle_cyc: got %b expected 0", o_bus_cyc);
      end
    end
  endtask

  task automatic test_single_fetch();
    i_ibus_req = 1'b1; i_ibus_addr = 30'h0000_0400;
    tick();
    vec_cnt++;
    if (bus_vec !== {1'b1, 1'b0, 4'hF, 32'h0000_1000, 32'h0}) begin
      err_cnt++; $display("FAIL fetch_bus: got %h expected %h", bus_vec, {1'b1, 1'b0, 4'hF, 32'h0000_1000, 32'h0});
    end
    vec_cnt++;
    if (o_ibus_ack !== 1'b0) begin
      err_cnt++; $display("FAIL fetch_early_ack: got %b expected 0", o_ibus_ack);
    end
    i_bus_ack = 1'b1; i_bus_rdata = 32'hDEAD_BEEF;
    tick();
    vec_cnt++;
    if ({o_ibus_ack, o_ibus_err, o_bus_cyc, o_ibus_rdata} !== {3'b100, 32'hDEAD_BEEF}) begin
      err_cnt++; $display("FAIL fetch_ack: got ack=%b err=%b cyc=%b rdata=%h expected 1 0 0 deadbeef",
                          o_ibus_ack, o_ibus_err, o_bus_cyc, o_ibus_rdata);
    end
    i_ibus_req = 1'b0; i_bus_ack = 1'b0; i_bus_rdata = 32'h0;
    tick();
    vec_cnt++;
    if ({o_ibus_ack, o_bus_cyc, o_ibus_rdata} !== {2'b00, 32'hDEAD_BEEF}) begin
      err_cnt++; $display("FAIL fetch_after: got ack=%b cyc=%b rdata=%h expected 0 0 deadbeef",
                          o_ibus_ack, o_bus_cyc, o_ibus_rdata);
    end
    tick();
  endtask

  // Data wins the first tie after reset, then the grants alternate.
  task automatic test_tie();
    int n_acks = 0;
    int bad = 0;
    logic [3:0] d_bits = '0;
    logic prev_ack = 1'b0;
    i_reset_n = 1'b0;
    tick();
    @(negedge i_clk);
    i_reset_n = 1'b1;
    tick();
    i_ibus_req = 1'b1; i_ibus_addr = 30'h0000_0040;
    i_dbus_req = 1'b1; i_dbus_we = 1'b0; i_dbus_sel = 4'hF; i_dbus_addr = 32'h0000_0100;
    i_bus_rdata = 32'hCAFE_0001;
    for (int k = 0; k < 12; k++) begin
      tick();
      i_bus_ack = o_bus_cyc;
      if (o_ibus_ack && o_dbus_ack) bad++;
      if ((o_ibus_ack || o_dbus_ack) && prev_ack) bad++;
      if (o_ibus_ack || o_dbus_ack) begin
        if (n_acks < 4) d_bits[n_acks] = o_dbus_ack;
        n_acks++;
      end
      prev_ack = o_ibus_ack || o_dbus_ack;
    end
    i_ibus_req = 1'b0; i_dbus_req = 1'b0; i_bus_ack = 1'b0;
    vec_cnt++;
    if (n_acks !== 4) begin
      err_cnt++; $display("FAIL tie_ack_count: got %0d expected 4", n_acks);
    end
    vec_cnt++;
    if (d_bits !== 4'b0101) begin
      err_cnt++; $display("FAIL tie_order (bit=1 means data): got %b expected 0101", d_bits);
    end
    vec_cnt++;
    if (bad !== 0) begin
      err_cnt++; $display("FAIL tie_pulse_shape: got %0d violations expected 0", bad);
    end
    tick(); tick();
    vec_cnt++;
    if ({o_ibus_rdata, o_bus_cyc} !== {32'hCAFE_0001, 1'b0}) begin
      err_cnt++; $display("FAIL tie_idle: got rdata=%h cyc=%b expected cafe0001 0", o_ibus_rdata, o_bus_cyc);
    end
  endtask

  task automatic test_wait_states();
    logic [69:0] exp_bus;
    exp_bus = {1'b1, 1'b1, 4'b1100, 32'h0000_2004, 32'hAABB_0000};
    i_dbus_req = 1'b1; i_dbus_we = 1'b1; i_dbus_sel = 4'b1100;
    i_dbus_addr = 32'h0000_2004; i_dbus_wdata = 32'hAABB_0000;
    i_bus_rdata = 32'h1234_5678;
    tick();
    // Changing the requester fields mid-cycle must not disturb the bus.
    i_dbus_addr = 32'hFFFF_FFFC; i_dbus_wdata = 32'h0; i_dbus_sel = 4'h1;
    for (int k = 0; k < 4; k++) begin
      vec_cnt++;
      if ({bus_vec, o_dbus_ack} !== {exp_bus, 1'b0}) begin
        err_cnt++; $display("FAIL wait_hold[%0d]: got %h ack=%b expected %h ack=0", k, bus_vec, o_dbus_ack, exp_bus);
      end
      if (k == 3) i_bus_ack = 1'b1;
      tick();
    end
    vec_cnt++;
    if ({o_dbus_ack, o_dbus_err, o_ibus_ack, o_bus_cyc, o_dbus_rdata} !== {4'b1000, 32'h1234_5678}) begin
      err_cnt++; $display("FAIL wait_ack: got ack=%b err=%b iack=%b cyc=%b rdata=%h expected 1 0 0 0 12345678",
                          o_dbus_ack, o_dbus_err, o_ibus_ack, o_bus_cyc, o_dbus_rdata);
    end
    i_dbus_req = 1'b0; i_bus_ack = 1'b0;
    tick();
    vec_cnt++;
    if (o_dbus_ack !== 1'b0) begin
      err_cnt++; $display("FAIL wait_ack_width: got %b expected 0", o_dbus_ack);
    end
    tick();
  endtask

  task automatic test_err_priority();
    i_dbus_req = 1'b1; i_dbus_we = 1'b0; i_dbus_sel = 4'hF; i_dbus_addr = 32'h0000_0200;
    tick();
    i_bus_ack = 1'b1; i_bus_err = 1'b1; i_bus_rdata = 32'hFFFF_0000;
    tick();
    vec_cnt++;
    if ({o_dbus_err, o_dbus_ack, o_dbus_rdata} !== {2'b10, 32'h1234_5678}) begin
      err_cnt++; $display("FAIL err_priority: got err=%b ack=%b rdata=%h expected 1 0 12345678",
                          o_dbus_err, o_dbus_ack, o_dbus_rdata);
    end
    i_dbus_req = 1'b0; i_bus_ack = 1'b0; i_bus_err = 1'b0;
    tick();
    vec_cnt++;
    if (o_dbus_err !== 1'b0) begin
      err_cnt++; $display("FAIL err_width: got %b expected 0", o_dbus_err);
    end
    tick();
  endtask

  task automatic test_timeout();
    int n_cyc = 0;
    logic seen = 1'b0;
    i_ibus_req = 1'b1; i_ibus_addr = 30'h0000_0010;
    i_bus_rdata = 32'h5555_5555;
    tick();
    for (int k = 0; k < 20; k++) begin
      if (o_ibus_err) begin
        seen = 1'b1;
        break;
      end
      if (o_bus_cyc) n_cyc++;
      tick();
    end
    vec_cnt++;
    if (seen !== 1'b1) begin
      err_cnt++; $display("FAIL timeout_err: got no err within 20 cycles expected err");
    end
    vec_cnt++;
    if (n_cyc !== 8) begin
      err_cnt++; $display("FAIL timeout_cyc_len: got %0d expected 8", n_cyc);
    end
    vec_cnt++;
    if ({o_ibus_ack, o_bus_cyc, o_ibus_rdata} !== {2'b00, 32'hCAFE_0001}) begin
      err_cnt++; $display("FAIL timeout_state: got ack=%b cyc=%b rdata=%h expected 0 0 cafe0001",
                          o_ibus_ack, o_bus_cyc, o_ibus_rdata);
    end
    i_ibus_req = 1'b0;
    tick();
    vec_cnt++;
    if (o_ibus_err !== 1'b0) begin
      err_cnt++; $display("FAIL timeout_err_width: got %b expected 0", o_ibus_err);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    i_dbus_req = 1'b1; i_dbus_we = 1'b0; i_dbus_sel = 4'hF; i_dbus_addr = 32'h0000_3000;
    i_bus_rdata = 32'h7777_7777;
    tick();
    tick();
    #2 i_reset_n = 1'b0;
    #1;
    vec_cnt++;
    if (o_bus_cyc !== 1'b0) begin
      err_cnt++; $display("FAIL rst_mid_cyc: got %b expected 0", o_bus_cyc);
    end
    i_bus_ack = 1'b1;
    tick();
    i_dbus_req = 1'b0; i_bus_ack = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (o_dbus_ack || o_dbus_err || o_bus_cyc) stray++;
    end
    vec_cnt++;
    if (stray !== 0) begin
      err_cnt++; $display("FAIL rst_mid_stray: got %0d active cycles expected 0", stray);
    end
    i_dbus_req = 1'b1; i_dbus_addr = 32'h0000_3008;
    tick();
    vec_cnt++;
    if ({o_bus_cyc, o_bus_addr} !== {1'b1, 32'h0000_3008}) begin
      err_cnt++; $display("FAIL rst_next_bus: got cyc=%b addr=%h expected 1 00003008", o_bus_cyc, o_bus_addr);
    end
    i_bus_ack = 1'b1; i_bus_rdata = 32'h0BAD_F00D;
    tick();
    vec_cnt++;
    if ({o_dbus_ack, o_dbus_rdata} !== {1'b1, 32'h0BAD_F00D}) begin
      err_cnt++; $display("FAIL rst_next_ack: got ack=%b rdata=%h expected 1 0badf00d", o_dbus_ack, o_dbus_rdata);
    end
    i_dbus_req = 1'b0; i_bus_ack = 1'b0;
    tick();
  endtask

  initial begin
    idle_inputs();
    i_bus_rdata = '0;
    i_reset_n = 1'b0;
    test_reset();
    test_single_fetch();
    test_tie();
    test_wait_states();
    test_err_priority();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
